wallace_mul_pipe: RTL and testbench

Parametrised, pipelined carry-save (Wallace) multiplier for the core's muldiv unit. Covers all four RV M-extension multiply ops (MUL, MULH, MULHSU, MULHU) at any operand width. Product computation is split across STAGES register stages, with a valid/ready handshake on both sides. Sits between the decode/issue stage and the writeback arbiter and carries the destination-register tag alongside each op.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/csa_row.sv | 17 +
 rtl/wallace_mul_pipe.sv | 168 ++++++++++++++++
 tb/tb_wallace_mul_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the muldiv unit: multiply op encodings and
// elaboration-time helpers that size the carry-save reduction tree.
package muldiv_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  // Rows left after lvl levels of 3:2 compression starting from n rows.
  function automatic int csa_rows(input int n, input int lvl);
    int r;
    r = n;
    for (int l = 0; l < lvl; l++) r = r - r / 3;
    return r;
  endfunction

  function automatic int csa_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = r - r / 3;
      l++;
    end
    return l;
  endfunction

  // First reduction level owned by pipeline stage s.
  function automatic int stage_lvl(input int s, input int stages, input int levels);
    return (s * levels) / stages;
  endfunction

endpackage

// File: rtl/csa_row.sv
// Parametrised-width 3:2 carry-save adder; carry row is pre-shifted left by one.
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);
  logic [W-1:0] w_maj;

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  // Top majority bit falls off: all arithmetic is modulo 2^W.
  assign o_carry = {w_maj[W-2:0], 1'b0};
endmodule

// File: rtl/wallace_mul_pipe.sv
// Elastic pipelined Baugh-Wooley/Wallace multiplier for MUL/MULH/MULHSU/MULHU.
// Define MUL_PERF_CNT_EN to add the perf_ops_o / perf_stall_o counters.
module wallace_mul_pipe
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
`ifdef MUL_PERF_CNT_EN
  output logic [31:0]      perf_ops_o,
  output logic [31:0]      perf_stall_o,
`endif
  output logic             busy_o
);
  localparam int N  = WIDTH + 1;
  localparam int PW = 2 * N;
  localparam int LV = csa_levels(N);

  logic [STAGES-1:0]            r_vld, r_hi;
  logic [STAGES-1:0][TAG_W-1:0] r_tag, w_tag_in;
  logic [STAGES-1:0]            w_adv, w_load, w_en, w_hi_in;
  logic [WIDTH-1:0]             r_res, w_res_nx;
  logic [N-1:0][PW-1:0]         w_pp;
  logic [N-1:0][PW-1:0]         w_lv [LV];
  logic [N-1:0][PW-1:0]         w_nx [LV];
  logic [PW-1:0]                w_prod;
  logic [N-1:0]                 w_ae, w_be;
  logic                         w_a_sgn, w_b_sgn, w_in_fire, w_nxt;

  // Elastic handshake: resolve from the output end back to the input.
  always_comb begin
    w_adv  = '0;
    w_load = '0;
    w_nxt  = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k]  = r_vld[k] && w_nxt;
      w_load[k] = !r_vld[k] || w_adv[k];
      w_nxt     = w_load[k];
    end
  end

  assign in_ready_o = !flush_i && w_load[0];
  assign w_in_fire  = in_valid_i && in_ready_o;

  assign w_a_sgn = (op_i == MUL_OP_MULH) || (op_i == MUL_OP_MULHSU);
  assign w_b_sgn = (op_i == MUL_OP_MULH);
  assign w_ae    = {w_a_sgn & a_i[WIDTH-1], a_i};
  assign w_be    = {w_b_sgn & b_i[WIDTH-1], b_i};

  // Baugh-Wooley: invert bits pairing exactly one sign bit, then add
  // constants at N and 2N-1 (both land in free slots of row 0).
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        w_pp[i][i+j] = (w_ae[j] & w_be[i]) ^ ((i == N - 1) != (j == N - 1));
    w_pp[0][N]    = 1'b1;
    w_pp[0][PW-1] = 1'b1;
  end

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int NI = csa_rows(N, l);
    localparam int G  = NI / 3;
    localparam int NO = NI - G;
    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_row #(.W(PW)) u_csa (
        .i_a    (w_lv[l][3*g]),
        .i_b    (w_lv[l][3*g+1]),
        .i_c    (w_lv[l][3*g+2]),
        .o_sum  (w_nx[l][g]),
        .o_carry(w_nx[l][G+g])
      );
    end
    for (genvar r = 0; r < NI - 3 * G; r++) begin : g_pass
      assign w_nx[l][2*G+r] = w_lv[l][3*G+r];
    end
    for (genvar z = NO; z < N; z++) begin : g_zero
      assign w_nx[l][z] = '0;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int LO = stage_lvl(s, STAGES, LV);
    localparam int HI = stage_lvl(s + 1, STAGES, LV);
    if (s == 0) begin : g_first
      assign w_lv[0]     = w_pp;
      assign w_en[0]     = w_in_fire;
      assign w_hi_in[0]  = (op_i != MUL_OP_MUL);
      assign w_tag_in[0] = tag_i;
    end else begin : g_mid
      assign w_en[s]     = w_adv[s-1];
      assign w_hi_in[s]  = r_hi[s-1];
      assign w_tag_in[s] = r_tag[s-1];
    end
    for (genvar l = LO + 1; l < HI; l++) begin : g_chain
      assign w_lv[l] = w_nx[l-1];
    end
    if (s < STAGES - 1) begin : g_rows
      logic [N-1:0][PW-1:0] r_rows;
      always_ff @(posedge clk_i) begin
        if (w_en[s]) r_rows <= w_nx[HI-1];
      end
      assign w_lv[HI] = r_rows;
    end
  end

  assign w_prod   = w_nx[LV-1][0] + w_nx[LV-1][1];
  assign w_res_nx = w_hi_in[STAGES-1] ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (!reset_i || flush_i) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (w_load[k]) r_vld[k] <= w_en[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_tag <= '0;
      r_hi  <= '0;
      r_res <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (w_en[k]) begin
          r_tag[k] <= w_tag_in[k];
          r_hi[k]  <= w_hi_in[k];
        end
      if (w_en[STAGES-1]) r_res <= w_res_nx;
    end
  end

  assign out_valid_o = r_vld[STAGES-1];
  assign result_o    = r_res;
  assign tag_o       = r_tag[STAGES-1];
  assign busy_o      = |r_vld;

`ifdef MUL_PERF_CNT_EN
  logic [31:0] r_perf_ops, r_perf_stall;
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (out_valid_o && out_ready_i)  r_perf_ops   <= r_perf_ops + 32'd1;
      if (out_valid_o && !out_ready_i) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end
  assign perf_ops_o   = r_perf_ops;
  assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Self-checking bench for wallace_mul_pipe: directed corner ops plus a random
// handshake/flush sweep against a queue-based arithmetic product model.
module tb_wallace_mul_pipe;
  import muldiv_pkg::*;

  localparam int W  = 32;
  localparam int S  = 2;
  localparam int TW = 5;

  logic          clk_i = 0, reset_i = 0, in_valid_i = 0, flush_i = 0, out_ready_i = 0;
  logic [W-1:0]  a_i = '0, b_i = '0;
  logic [1:0]    op_i = '0;
  logic [TW-1:0] tag_i = '0;
  logic          in_ready_o, out_valid_o, busy_o;
  logic [W-1:0]  result_o;
  logic [TW-1:0] tag_o;
`ifdef MUL_PERF_CNT_EN
  logic [31:0]   perf_ops_o, perf_stall_o;
`endif

  wallace_mul_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .op_i(op_i), .tag_i(tag_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .tag_o(tag_o),
`ifdef MUL_PERF_CNT_EN
    .perf_ops_o(perf_ops_o), .perf_stall_o(perf_stall_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0;
  int   m_ops = 0, m_stall = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Extend each operand to 2W+2 bits by the op's signedness; the wrapped
  // product then holds the exact signed/unsigned product in its low 2W bits.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W+1:0] xa, xb, p;
    bit asg, bsg;
    asg = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    bsg = (op == MUL_OP_MULH);
    xa  = asg ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
    xb  = bsg ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    p   = xa * xb;
    return (op == MUL_OP_MUL) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    v = W'($urandom);
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = '1;
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = {1'b0, {(W-1){1'b1}}};
      default: ;
    endcase
    return v;
  endfunction

  // Scoreboard: at each negedge compare outputs, then apply the coming edge.
  always @(negedge clk_i) if (mon_en) begin
    chk("busy", busy_o, q.size() != 0);
    chk("in_ready", in_ready_o, !flush_i && (q.size() < S || out_ready_i));
    if (out_valid_o) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_out: out_valid with nothing in flight, tag %0h", tag_o);
      end else begin
        chk("result", result_o, q[0].res);
        chk("tag", tag_o, q[0].tag);
      end
    end
    if (!reset_i) begin
      q.delete();
      m_ops   = 0;
      m_stall = 0;
    end else begin
      if (out_valid_o && out_ready_i)  m_ops++;
      if (out_valid_o && !out_ready_i) m_stall++;
      if (flush_i) q.delete();
      else begin
        if (out_valid_o && out_ready_i && q.size() > 0) void'(q.pop_front());
        if (in_valid_i && in_ready_o) q.push_back('{model(op_i, a_i, b_i), tag_i});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op into an idle pipe and check its latency and value.
  task automatic issue1(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input logic [W-1:0] exp, input string name);
    op_i = op; a_i = a; b_i = b; tag_i = tag;
    in_valid_i = 1; out_ready_i = 1;
    chk({name, "_ready"}, in_ready_o, 1);
    tick();
    in_valid_i = 0;
    for (int k = 0; k < S - 1; k++) begin
      chk({name, "_early"}, out_valid_o, 0);
      tick();
    end
    chk({name, "_valid"}, out_valid_o, 1);
    chk({name, "_res"}, result_o, exp);
    chk({name, "_tag"}, tag_o, tag);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt, drn, budget;

    repeat (2) tick();
    mon_en = 1;
    tick();
    reset_i = 1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_tag", tag_o, 0);

    chk("model_mulh_min", model(MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("model_mulhsu", model(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

    issue1(MUL_OP_MUL,    32'd7,         32'd6,         5'd3,  32'd42,        "mul_7x6");
    issue1(MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, "mulh_min");
    issue1(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, "mulhu_ff");
    issue1(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, "mulhsu_ff");
    issue1(MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0001, "mul_ff");
    issue1(MUL_OP_MULH,   32'hFFFF_FFFE, 32'd3,         5'd8,  32'hFFFF_FFFF, "mulh_neg");

    // Back-to-back issue against a 5-cycle output stall.
    nxt = 1;
    drn = 1;
    for (int c = 0; c < 16; c++) begin
      out_ready_i = (c >= 5);
      in_valid_i  = (nxt <= 4);
      tag_i       = nxt[TW-1:0];
      op_i        = MUL_OP_MUL;
      a_i         = W'(nxt);
      b_i         = 32'd10;
      @(negedge clk_i);
      if (c == 2) chk("stall_ready_low", in_ready_o, 0);
      if (c >= 2 && c < 5) begin
        chk("stall_valid", out_valid_o, 1);
        chk("stall_hold_tag", tag_o, 1);
        chk("stall_hold_res", result_o, 10);
      end
      if (out_valid_o && out_ready_i) begin
        chk("drain_order", tag_o, drn);
        drn++;
      end
      if (in_valid_i && in_ready_o) nxt++;
      tick();
    end
    chk("drain_count", drn, 5);

    // Flush with two ops in flight and a request presented.
    out_ready_i = 0;
    op_i = MUL_OP_MULHU;
    for (int t = 0; t < 2; t++) begin
      in_valid_i = 1;
      tag_i = TW'(10 + t);
      a_i = pick();
      b_i = pick();
      tick();
    end
    chk("pre_flush_busy", busy_o, 1);
    flush_i = 1;
    tag_i = 5'd9;
    #1 chk("flush_ready", in_ready_o, 0);
    tick();
    flush_i = 0;
    in_valid_i = 0;
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", out_valid_o, 0);
    repeat (3) begin
      tick();
      chk("flush_quiet", out_valid_o, 0);
    end

    // Reset in the middle of a stall.
    out_ready_i = 0;
    op_i = MUL_OP_MUL; a_i = 32'd3; b_i = 32'd3; tag_i = 5'd12;
    in_valid_i = 1;
    tick();
    in_valid_i = 0;
    budget = 0;
    while (!out_valid_o && budget < 10) begin
      tick();
      budget++;
    end
    chk("pre_rst_valid", out_valid_o, 1);
    reset_i = 0;
    tick();
    reset_i = 1;
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_result", result_o, 0);
    chk("midrst_tag", tag_o, 0);
    issue1(MUL_OP_MUL, 32'd5, 32'd9, 5'd2, 32'd45, "post_rst");

    // Random sweep: ops, operands, handshake and occasional flush.
    for (int c = 0; c < 4000; c++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 99) == 0);
      op_i        = 2'($urandom_range(0, 3));
      a_i         = pick();
      b_i         = pick();
      tag_i       = TW'($urandom);
      tick();
    end
    in_valid_i = 0;
    flush_i = 0;
    out_ready_i = 1;
    budget = 0;
    while ((q.size() != 0 || busy_o) && budget < 20) begin
      tick();
      budget++;
    end
    chk("final_drain", q.size(), 0);
    chk("final_busy", busy_o, 0);
`ifdef MUL_PERF_CNT_EN
    chk("perf_ops", perf_ops_o, m_ops);
    chk("perf_stall", perf_stall_o, m_stall);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
